// File: rtl/fp_rnd_pipe_pkg.sv
// Shared types and constants for the rounding/packing pipeline.
// Stage records carry only what the next stage still needs.
package fp_wire;

    typedef struct packed {
        logic        sig;
        logic [13:0] expo;
        logic [53:0] mant;
        logic [1:0]  rema;
        logic [1:0]  fmt;
        logic [2:0]  rm;
        logic [2:0]  grs;
        logic        snan;
        logic        qnan;
        logic        dbz;
        logic        inf;
        logic        zero;
    } fp_rnd_in_type;

    typedef enum logic [2:0] {
        RM_RNE = 3'd0,
        RM_RTZ = 3'd1,
        RM_RDN = 3'd2,
        RM_RUP = 3'd3,
        RM_RMM = 3'd4
    } fp_rm_e;

    typedef struct packed {
        logic        sig;
        logic [13:0] expo;
        logic [53:0] mant;
        logic        dbl;
        logic [2:0]  rm;
        logic        nx;
        logic        uf;
        logic        snan;
        logic        qnan;
        logic        dbz;
        logic        inf;
        logic        zero;
    } fp_rnd_s1_type;

    typedef struct packed {
        logic [63:0] result;
        logic [4:0]  flags;
    } fp_rnd_s2_type;

    localparam logic [31:0] NAN_S      = 32'h7FC0_0000;
    localparam logic [63:0] NAN_D      = 64'h7FF8_0000_0000_0000;
    localparam logic [31:0] NAN_BOX    = 32'hFFFF_FFFF;
    localparam logic [13:0] EXPO_MAX_S = 14'd255;
    localparam logic [13:0] EXPO_MAX_D = 14'd2047;

endpackage

// File: rtl/fp_rnd_dec.sv
// Rounding increment decision; shared with the integer conversion path.
module fp_rnd_dec
    import fp_wire::*;
(
    input  logic [2:0] rm_i,
    input  logic       sig_i,
    input  logic       lsb_i,
    input  logic [2:0] grs_i,
    output logic       inc_o
);

    logic nx;

    always_comb begin
        nx    = |grs_i;
        // Reserved modes 5-7 fall through to round-to-nearest-even.
        inc_o = grs_i[2] & (lsb_i | grs_i[1] | grs_i[0]);
        case (rm_i)
            RM_RTZ:  inc_o = 1'b0;
            RM_RDN:  inc_o = sig_i & nx;
            RM_RUP:  inc_o = ~sig_i & nx;
            RM_RMM:  inc_o = grs_i[2];
            default: ;
        endcase
    end

endmodule

// File: rtl/fp_rnd_pipe.sv
// Two-stage rounding and IEEE-754 packing unit with valid/ready on both sides.
// S1 rounds the mantissa; S2 range-checks, resolves specials and packs.
module fp_rnd_pipe
    import fp_wire::*;
(
    input  logic          clock,
    input  logic          reset,
    input  logic          flush,
    input  fp_rnd_in_type fp_rnd_i,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [63:0]   result,
    output logic [4:0]    flags,
    output logic          out_valid,
    input  logic          out_ready
);

    fp_rnd_s1_type s1_d, s1_q;
    fp_rnd_s2_type s2_d, s2_q;
    logic          s1_valid_q, s2_valid_q;
    logic          adv1, adv2;

    logic [2:0]    grs_m;
    logic          inc, dbl, carry, hidden;
    logic [53:0]   mant_r;
    logic [13:0]   expo_r;

    assign dbl   = (fp_rnd_i.fmt == 2'd1);
    assign grs_m = {fp_rnd_i.grs[2:1], fp_rnd_i.grs[0] | (|fp_rnd_i.rema)};

    fp_rnd_dec u_dec (
        .rm_i  (fp_rnd_i.rm),
        .sig_i (fp_rnd_i.sig),
        .lsb_i (fp_rnd_i.mant[0]),
        .grs_i (grs_m),
        .inc_o (inc)
    );

    always_comb begin
        mant_r = fp_rnd_i.mant + 54'(inc);
        expo_r = fp_rnd_i.expo;
        carry  = dbl ? mant_r[53] : mant_r[24];
        if (carry) begin
            mant_r = mant_r >> 1;
            expo_r = fp_rnd_i.expo + 14'd1;
        end
        // A subnormal that rounds up into the hidden bit becomes the smallest normal.
        hidden = dbl ? mant_r[52] : mant_r[23];
        if (fp_rnd_i.expo == '0 && hidden) expo_r = 14'd1;

        s1_d.sig  = fp_rnd_i.sig;
        s1_d.expo = expo_r;
        s1_d.mant = mant_r;
        s1_d.dbl  = dbl;
        s1_d.rm   = fp_rnd_i.rm;
        s1_d.nx   = |grs_m;
        s1_d.uf   = (fp_rnd_i.expo == '0) && (|grs_m);
        s1_d.snan = fp_rnd_i.snan;
        s1_d.qnan = fp_rnd_i.qnan;
        s1_d.dbz  = fp_rnd_i.dbz;
        s1_d.inf  = fp_rnd_i.inf;
        s1_d.zero = fp_rnd_i.zero;
    end

    logic        ovf, to_max;
    logic [31:0] r32, inf32;
    logic [63:0] r64, inf64;

    always_comb begin
        ovf    = s1_q.dbl ? (s1_q.expo >= EXPO_MAX_D) : (s1_q.expo >= EXPO_MAX_S);
        to_max = (s1_q.rm == RM_RTZ) || (s1_q.rm == RM_RDN && !s1_q.sig)
              || (s1_q.rm == RM_RUP && s1_q.sig);
        inf32  = {s1_q.sig, 8'hFF, 23'h0};
        inf64  = {s1_q.sig, 11'h7FF, 52'h0};
        r32    = {s1_q.sig, s1_q.expo[7:0], s1_q.mant[22:0]};
        r64    = {s1_q.sig, s1_q.expo[10:0], s1_q.mant[51:0]};
        s2_d.flags = {2'b00, ovf, s1_q.uf, s1_q.nx | ovf};
        if (ovf) begin
            r32 = to_max ? {s1_q.sig, 8'hFE, 23'h7F_FFFF} : inf32;
            r64 = to_max ? {s1_q.sig, 11'h7FE, 52'hF_FFFF_FFFF_FFFF} : inf64;
        end
        if (s1_q.snan || s1_q.qnan) begin
            r32        = NAN_S;
            r64        = NAN_D;
            s2_d.flags = {s1_q.snan, 4'b0000};
        end else if (s1_q.dbz || s1_q.inf) begin
            r32        = inf32;
            r64        = inf64;
            s2_d.flags = {1'b0, s1_q.dbz, 3'b000};
        end else if (s1_q.zero) begin
            r32        = {s1_q.sig, 31'h0};
            r64        = {s1_q.sig, 63'h0};
            s2_d.flags = '0;
        end
        s2_d.result = s1_q.dbl ? r64 : {NAN_BOX, r32};
    end

    assign adv2      = ~s2_valid_q | out_ready;
    assign adv1      = ~s1_valid_q | adv2;
    assign in_ready  = adv1;
    assign out_valid = s2_valid_q;
    assign result    = s2_q.result;
    assign flags     = s2_q.flags;

    always_ff @(posedge clock) begin
        if (!reset) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_q       <= '0;
        end else if (flush) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
        end else begin
            if (adv2) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) s2_q <= s2_d;
            end
            if (adv1) begin
                s1_valid_q <= in_valid;
                if (in_valid) s1_q <= s1_d;
            end
        end
    end

endmodule
